// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - ADC scan sequencer with averaging, result bank and protocol error flags
module adc_scan_scheduler #(
    parameter int NUM_CH         = 6,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic [NUM_CH-1:0]    ch_enable,
    output logic                 cmd_valid,
    output logic [4:0]           cmd_channel,
    input  logic                 cmd_ready,
    input  logic                 rsp_valid,
    input  logic [4:0]           rsp_channel,
    input  logic [11:0]          rsp_data,
    output logic [NUM_CH*12-1:0] adc_data,
    output logic [NUM_CH-1:0]    ch_update,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_mismatch,
    output logic                 err_overrun
);
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] NCONV    = CNT_W'(1 << AVG_LOG2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

    state_t              r_state;
    logic [NUM_CH-1:0]   r_mask;
    logic [4:0]          r_cur;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_cmd_valid;
    logic [4:0]          r_cmd_channel;
    logic [NUM_CH*12-1:0] r_adc;
    logic [NUM_CH-1:0]   r_ch_update;
    logic                r_scan_done;
    logic                r_busy;
    logic                r_err_timeout;
    logic                r_err_mismatch;
    logic                r_err_overrun;

    logic [4:0]          w_first_ch;
    logic [4:0]          w_next_ch;
    logic                w_has_next;

    // Descending loops so the lowest qualifying channel wins.
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = r_cur;
        w_has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i])
                w_first_ch = 5'(i);
            if (r_mask[i] && (5'(i) > r_cur)) begin
                w_next_ch  = 5'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_mask         <= '0;
            r_cur          <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_tmo          <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_channel  <= '0;
            r_adc          <= '0;
            r_ch_update    <= '0;
            r_scan_done    <= 1'b0;
            r_busy         <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_mismatch <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_ch_update <= '0;
            r_scan_done <= 1'b0;
            // A tick landing on the scan_done cycle is still part of the old scan.
            if (sample_tick && ((r_state != S_IDLE) || r_scan_done))
                r_err_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (sample_tick && !r_scan_done && (|ch_enable)) begin
                        r_mask        <= ch_enable;
                        r_cur         <= w_first_ch;
                        r_acc         <= '0;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                        r_cmd_valid   <= 1'b1;
                        r_cmd_channel <= w_first_ch;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_cmd_valid && cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_tmo       <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid && (rsp_channel == r_cur)) begin
                        r_acc <= r_acc + ACC_W'(rsp_data);
                        r_cnt <= r_cnt + 1'b1;
                        if ((r_cnt + 1'b1) == NCONV) begin
                            r_state <= S_STORE;
                        end else begin
                            r_cmd_valid   <= 1'b1;
                            r_cmd_channel <= r_cur;
                            r_state       <= S_ISSUE;
                        end
                    end else begin
                        if (rsp_valid)
                            r_err_mismatch <= 1'b1;
                        if (r_tmo == TMO_LAST) begin
                            // Channel abandoned: result bank left untouched.
                            r_err_timeout <= 1'b1;
                            r_acc         <= '0;
                            r_cnt         <= '0;
                            if (w_has_next) begin
                                r_cur         <= w_next_ch;
                                r_cmd_valid   <= 1'b1;
                                r_cmd_channel <= w_next_ch;
                                r_state       <= S_ISSUE;
                            end else begin
                                r_scan_done <= 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                S_STORE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (5'(i) == r_cur) begin
                            r_adc[i*12 +: 12] <= r_acc[ACC_W-1:AVG_LOG2];
                            r_ch_update[i]    <= 1'b1;
                        end
                    end
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (w_has_next) begin
                        r_cur         <= w_next_ch;
                        r_cmd_valid   <= 1'b1;
                        r_cmd_channel <= w_next_ch;
                        r_state       <= S_ISSUE;
                    end else begin
                        r_scan_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_channel  = r_cmd_channel;
    assign adc_data     = r_adc;
    assign ch_update    = r_ch_update;
    assign scan_done    = r_scan_done;
    assign busy         = r_busy;
    assign err_timeout  = r_err_timeout;
    assign err_mismatch = r_err_mismatch;
    assign err_overrun  = r_err_overrun;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb/tb_adc_scan_scheduler.sv - randomized scenario bench for adc_scan_scheduler
module tb_adc_scan_scheduler;
    localparam int NUM_CH   = 6;
    localparam int AVG_LOG2 = 2;
    localparam int TMO      = 64;
    localparam int NCONV    = 1 << AVG_LOG2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 sample_tick;
    logic [NUM_CH-1:0]    ch_enable;
    logic                 cmd_ready;
    logic                 rsp_valid;
    logic [4:0]           rsp_channel;
    logic [11:0]          rsp_data;
    logic                 cmd_valid;
    logic [4:0]           cmd_channel;
    logic [NUM_CH*12-1:0] adc_data;
    logic [NUM_CH-1:0]    ch_update;
    logic                 scan_done;
    logic                 busy;
    logic                 err_timeout;
    logic                 err_mismatch;
    logic                 err_overrun;

    adc_scan_scheduler #(.NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .ch_enable(ch_enable),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .adc_data(adc_data), .ch_update(ch_update), .scan_done(scan_done), .busy(busy),
        .err_timeout(err_timeout), .err_mismatch(err_mismatch), .err_overrun(err_overrun)
    );

    int vectors = 0;
    int errors  = 0;
    logic [11:0]       exp_adc [NUM_CH];
    logic [NUM_CH-1:0] upd_q [$];
    int                done_cnt;
    logic [NUM_CH-1:0] done_upd;
    bit                mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ch_update != '0) upd_q.push_back(ch_update);
            if (scan_done) begin
                done_cnt++;
                done_upd = ch_update;
            end
        end
    end

    // dmode: 0 random data, 1 data = 0x100+ch, 2 fixed table per conversion index
    task automatic run_scan(input logic [NUM_CH-1:0] mask, input int silent, input int mm_ch,
                            input int stall, input int dmode, input bit tick_at_done);
        int cmds[$];
        logic [NUM_CH-1:0] exp_upd[$];
        logic [NUM_CH-1:0] last_upd;
        int sum[NUM_CH];
        int cidx[NUM_CH];
        logic [11:0] tbl[4];
        logic [11:0] d;
        bit mm_done;
        int n, ch;
        tbl = '{12'h004, 12'h008, 12'h00C, 12'h011};
        mm_done = 1'b0;
        last_upd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum[c] = 0;
            cidx[c] = 0;
            if (mask[c]) begin
                if (c == silent) begin
                    cmds.push_back(c);
                    last_upd = '0;
                end else begin
                    for (int k = 0; k < NCONV; k++) cmds.push_back(c);
                    exp_upd.push_back(NUM_CH'(1) << c);
                    last_upd = NUM_CH'(1) << c;
                end
            end
        end
        upd_q.delete();
        done_cnt = 0;
        done_upd = '0;
        mon_en = 1'b1;
        @(negedge clk);
        ch_enable = mask;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        ch_enable = NUM_CH'($urandom);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL scan_busy: busy=%b required 1", busy);
        end
        foreach (cmds[k]) begin
            ch = cmds[k];
            n = 0;
            while (!cmd_valid && n < TMO + 50) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_channel !== 5'(ch)) begin
                errors++;
                $display("FAIL cmd_issue: valid=%b channel=%0d required valid=1 channel=%0d", cmd_valid, cmd_channel, ch);
            end
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                vectors++;
                if (cmd_valid !== 1'b1 || cmd_channel !== 5'(ch)) begin
                    errors++;
                    $display("FAIL cmd_hold: valid=%b channel=%0d required valid=1 channel=%0d", cmd_valid, cmd_channel, ch);
                end
            end
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            vectors++;
            if (cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL cmd_drop: valid=%b required 0 after acceptance", cmd_valid);
            end
            if (ch == silent) begin
                n = 0;
                while (!err_timeout && n < TMO + 20) begin
                    @(negedge clk);
                    n++;
                end
                vectors++;
                if (err_timeout !== 1'b1 || n != TMO) begin
                    errors++;
                    $display("FAIL timeout: err_timeout=%b after %0d cycles required 1 after %0d", err_timeout, n, TMO);
                end
            end else begin
                if (ch == mm_ch && !mm_done) begin
                    mm_done = 1'b1;
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    rsp_valid = 1'b1;
                    rsp_channel = 5'((ch + 4) % NUM_CH);
                    rsp_data = 12'hFFF;
                    @(negedge clk);
                    rsp_valid = 1'b0;
                    vectors++;
                    if (err_mismatch !== 1'b1) begin
                        errors++;
                        $display("FAIL mismatch: err_mismatch=%b required 1", err_mismatch);
                    end
                end
                repeat ($urandom_range(0, 10)) @(negedge clk);
                case (dmode)
                    1: d = 12'h100 + 12'(ch);
                    2: d = tbl[cidx[ch] % 4];
                    default: d = 12'($urandom);
                endcase
                sum[ch] += int'(d);
                cidx[ch]++;
                rsp_valid = 1'b1;
                rsp_channel = 5'(ch);
                rsp_data = d;
                @(negedge clk);
                rsp_valid = 1'b0;
            end
        end
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c] && c != silent) exp_adc[c] = 12'(sum[c] >> AVG_LOG2);
        n = 0;
        while (!scan_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (scan_done !== 1'b1) begin
            errors++;
            $display("FAIL scan_done_seen: scan_done=%b required 1", scan_done);
        end
        if (tick_at_done) begin
            ch_enable = mask;
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            vectors++;
            if (err_overrun !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL tick_at_done: err_overrun=%b busy=%b required 1 0", err_overrun, busy);
            end
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        vectors++;
        if (done_cnt != 1 || done_upd !== last_upd || busy !== 1'b0) begin
            errors++;
            $display("FAIL scan_end: done_cnt=%0d upd=%b busy=%b required 1 %b 0", done_cnt, done_upd, busy, last_upd);
        end
        vectors++;
        if (upd_q.size() != exp_upd.size()) begin
            errors++;
            $display("FAIL upd_count: %0d pulses required %0d", upd_q.size(), exp_upd.size());
        end else begin
            foreach (exp_upd[k]) begin
                vectors++;
                if (upd_q[k] !== exp_upd[k]) begin
                    errors++;
                    $display("FAIL upd_order: pulse %0d = %b required %b", k, upd_q[k], exp_upd[k]);
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            vectors++;
            if (adc_data[c*12 +: 12] !== exp_adc[c]) begin
                errors++;
                $display("FAIL adc_data ch%0d: %h required %h", c, adc_data[c*12 +: 12], exp_adc[c]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sample_tick = 1'b0; ch_enable = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0;
        for (int c = 0; c < NUM_CH; c++) exp_adc[c] = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd_valid, cmd_channel, adc_data, ch_update, scan_done, busy, err_timeout, err_mismatch, err_overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b cmd_valid=%b adc=%h required all 0", busy, cmd_valid, adc_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_tick();
        ch_enable = '0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy !== 1'b0 || scan_done !== 1'b0 || cmd_valid !== 1'b0 || err_overrun !== 1'b0) begin
                errors++;
                $display("FAIL empty_tick: busy=%b done=%b cmd_valid=%b overrun=%b required 0", busy, scan_done, cmd_valid, err_overrun);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_all_channels();
        run_scan(6'b111111, -1, -1, 0, 1, 1'b0);
    endtask

    task automatic test_average();
        run_scan(6'b000100, -1, -1, 0, 2, 1'b0);
        vectors++;
        if (adc_data[2*12 +: 12] !== 12'h00A) begin
            errors++;
            $display("FAIL average_ch2: %h required 00a", adc_data[2*12 +: 12]);
        end
    endtask

    task automatic test_stall();
        run_scan(6'b001000, -1, -1, 20, 0, 1'b0);
    endtask

    task automatic test_mismatch();
        run_scan(6'b000011, -1, 1, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        vectors++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pre: err_timeout=%b required 0", err_timeout);
        end
        run_scan(6'b111000, 3, -1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] m;
        for (int r = 0; r < 6; r++) begin
            m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            run_scan(m, -1, -1, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_overrun_reset();
        int n;
        @(negedge clk);
        ch_enable = 6'b111111;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        n = 0;
        while (!cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        vectors++;
        if (err_overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun: err_overrun=%b busy=%b required 1 1", err_overrun, busy);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_valid, cmd_channel, adc_data, ch_update, scan_done, busy, err_timeout, err_mismatch, err_overrun} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b overrun=%b adc=%h required all 0", busy, err_overrun, adc_data);
        end
        for (int c = 0; c < NUM_CH; c++) exp_adc[c] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        rsp_valid = 1'b1;
        rsp_channel = 5'd0;
        rsp_data = 12'h555;
        @(negedge clk);
        rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy !== 1'b0 || ch_update !== '0 || adc_data !== '0 || cmd_valid !== 1'b0 || err_mismatch !== 1'b0) begin
                errors++;
                $display("FAIL late_rsp: busy=%b upd=%b adc=%h cmd_valid=%b mismatch=%b required all 0", busy, ch_update, adc_data, cmd_valid, err_mismatch);
            end
            @(negedge clk);
        end
        run_scan(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), -1, -1, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_empty_tick();
        test_all_channels();
        test_average();
        test_stall();
        test_mismatch();
        test_timeout();
        test_random();
        test_overrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
